otter_io_intr_ctrl: RTL and testbench
=====================================

// Module: otter_io_intr_ctrl
// PURPOSE
//  Memory-mapped I/O and interrupt controller on the OTTER MCU IOBUS (downstream of IOBUS_ADDR/OUT/WR,
//  upstream of IOBUS_IN and INTR). Owns switches, LEDs, debounced buttons and a periodic timer.
//  Merges timer and button events into one level-sensitive INTR line.
//  Firmware clears INTR via a write-1-to-clear status register.
// PARAMETERS
//  SW_WIDTH         16   switch inputs
//  LED_WIDTH        16   LED outputs
//  BTN_WIDTH        4    button inputs (1..8)
//  DEBOUNCE_CYCLES  8    consecutive stable cycles before a debounced button changes (>=2)
// PORTS
//  CLK          in   1          system clock, shared with MCU
//  RST_N        in   1          asynchronous, active-low reset
//  IOBUS_ADDR   in   32         MCU IO address (ALU result)
//  IOBUS_OUT    in   32         MCU write data (rs2)
//  IOBUS_WR     in   1          IO write strobe, one cycle per store
//  IOBUS_IN     out  32         read data to MCU, combinational from IOBUS_ADDR
//  INTR         out  1          interrupt request to MCU, registered level
//  SWITCHES     in   SW_WIDTH   raw switch pins
//  BUTTONS      in   BTN_WIDTH  raw button pins (asynchronous)
//  LEDS         out  LED_WIDTH  LED register
// BEHAVIOUR
//  Register map (full 32-bit decode, word access):
//   0x1100_0000 SW    RO   synchronised switches, zero-extended
//   0x1100_0020 BTN   RO   debounced buttons, zero-extended
//   0x1100_0040 LED   RW   LED register
//   0x1100_0060 TCTL  RW   [0]=EN
//   0x1100_0064 TPER  RW   period; any write zeroes the count
//   0x1100_0068 TCNT  RO   current count
//   0x1100_006C ISTAT W1C  [0]=TMR_PEND, [BTN_WIDTH:1]=BTN_PEND
//   0x1100_0070 IMASK RW   same bit layout as ISTAT
//  - Unmapped reads return 0. Writes to RO or unmapped addresses are ignored.
//  - A write takes effect on the CLK edge where IOBUS_WR=1.
//  - IOBUS_IN has zero-cycle latency: a pure mux of registered state.
//  - Reset (async assert, sync release): LEDS=0, TCTL=0, TPER=0, TCNT=0, ISTAT=0, IMASK=0, INTR=0,
//    sync/debounce flops=0, debounce counters=0.
//  - Reset mid-operation discards any pending interrupt.
//  - SW: 2-flop synchroniser, so 2-cycle latency from pin to read value.
//  - BTN: 2-flop synchroniser feeding a per-bit debouncer.
//    - Counter resets whenever the synced value differs from the held debounced value.
//    - When the counter reaches DEBOUNCE_CYCLES-1 with a differing value, the debounced value updates
//      and the counter clears.
//    - A glitch shorter than DEBOUNCE_CYCLES never propagates.
//    - A debounced 0->1 transition sets BTN_PEND[i]. Release (1->0) sets nothing.
//  - Timer, when EN=1 and TPER!=0:
//    - TCNT increments each cycle.
//    - At TCNT==TPER-1: TCNT wraps to 0 and TMR_PEND sets.
//    - TPER==0: TCNT holds 0 and no pend is raised.
//    - EN=0: TCNT holds its value.
//    - A TPER write zeroes TCNT on the same edge, with no pend that cycle.
//  - ISTAT: writing 1 clears a bit, writing 0 leaves it. If set and clear occur on the same edge,
//    set wins, so no event is lost.
//  - INTR <= |(ISTAT & IMASK), registered. It stays high until firmware clears every masked pend bit.
//    This level survives the MCU's MIE gating and interrupt-entry latency.
//  - Clearing IMASK drops INTR one cycle later; pend bits are retained.
// STRUCTURE
//  - otter_io_pkg holds:
//    - localparam address constants (IO_SW_ADDR ... IO_IMASK_ADDR);
//    - ISTAT bit indices (TMR_PEND_BIT=0, BTN_PEND_LSB=1).
//  - Sub-module otter_btn_debounce (#(DEBOUNCE_CYCLES)): one per button bit via generate.
//    - Contains the synchroniser, stability counter and debounced flop.
//    - Outputs: level and one-cycle rise pulse.
//  - Top level contains address decode, registers, timer, ISTAT/IMASK logic and the read mux.
// TESTING
//  1. Assert RST_N=0 mid-count with TMR_PEND=1 -> INTR=0, TCNT=0, LEDS=0 immediately.
//     After release, all registers read 0.
//  2. Write TPER=5, TCTL=1, IMASK=1 -> TMR_PEND set exactly 5 cycles after EN.
//     INTR high the next cycle. Write ISTAT=1 -> INTR low the cycle after.
//  3. BUTTONS[2] high for 5 cycles, then low -> no BTN_PEND. Hold 12 cycles -> BTN reads 0x4,
//     ISTAT[3]=1. With IMASK=0x8, INTR goes to 1.
//  4. W1C ISTAT=1 on the same edge as a timer wrap -> TMR_PEND remains 1.
//  5. Write LED=0xA5A5 -> LEDS=0xA5A5 next cycle, readback 0x0000A5A5.
//     Write to 0x1100_0000 -> ignored. Read 0x1100_0010 -> 0.
//  6. SWITCHES=0x1234 -> SW reads 0x1234 two cycles later. TPER=0 with EN=1 -> TCNT stays 0, no pend.

Source files
------------

// File: rtl/otter_io_pkg.sv
// rtl/otter_io_pkg.sv - OTTER IOBUS address map and interrupt status bit layout
package otter_io_pkg;

    localparam logic [31:0] IO_SW_ADDR    = 32'h1100_0000;
    localparam logic [31:0] IO_BTN_ADDR   = 32'h1100_0020;
    localparam logic [31:0] IO_LED_ADDR   = 32'h1100_0040;
    localparam logic [31:0] IO_TCTL_ADDR  = 32'h1100_0060;
    localparam logic [31:0] IO_TPER_ADDR  = 32'h1100_0064;
    localparam logic [31:0] IO_TCNT_ADDR  = 32'h1100_0068;
    localparam logic [31:0] IO_ISTAT_ADDR = 32'h1100_006C;
    localparam logic [31:0] IO_IMASK_ADDR = 32'h1100_0070;

    localparam int TMR_PEND_BIT = 0;
    localparam int BTN_PEND_LSB = 1;

endpackage

// File: rtl/otter_btn_debounce.sv
// rtl/otter_btn_debounce.sv - one-bit button synchroniser and stability-count debouncer
module otter_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;
    logic          differs;
    logic          settle;

    assign differs  = (sync_2 != btn_level);
    assign settle   = differs && (stable_cnt == CNT_MAX);
    // Pulse is valid in the cycle whose edge commits the new high level.
    assign btn_rise = settle && sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            stable_cnt <= '0;
            btn_level  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            if (!differs) begin
                stable_cnt <= '0;
            end else if (settle) begin
                stable_cnt <= '0;
                btn_level  <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/otter_io_intr_ctrl.sv
// rtl/otter_io_intr_ctrl.sv - OTTER memory-mapped switches/LEDs/buttons/timer with merged interrupt
module otter_io_intr_ctrl #(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int BTN_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    output logic                 INTR,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    input  logic [BTN_WIDTH-1:0] BUTTONS,
    output logic [LED_WIDTH-1:0] LEDS
);
    import otter_io_pkg::*;

    localparam int IW = BTN_WIDTH + 1;

    logic [SW_WIDTH-1:0]  sw_sync_1;
    logic [SW_WIDTH-1:0]  sw_sync_2;
    logic [BTN_WIDTH-1:0] btn_level;
    logic [BTN_WIDTH-1:0] btn_rise;
    logic                 tmr_en;
    logic [31:0]          tper;
    logic [31:0]          tcnt;
    logic [IW-1:0]        istat;
    logic [IW-1:0]        imask;
    logic [IW-1:0]        istat_set;
    logic [IW-1:0]        istat_clr;
    logic                 wr_led, wr_tctl, wr_tper, wr_istat, wr_imask;
    logic                 tmr_run, tmr_wrap;

    genvar g;
    generate
        for (g = 0; g < BTN_WIDTH; g++) begin : g_btn
            otter_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk      (CLK),
                .rst_n    (RST_N),
                .btn_raw  (BUTTONS[g]),
                .btn_level(btn_level[g]),
                .btn_rise (btn_rise[g])
            );
        end
    endgenerate

    assign wr_led   = IOBUS_WR && (IOBUS_ADDR == IO_LED_ADDR);
    assign wr_tctl  = IOBUS_WR && (IOBUS_ADDR == IO_TCTL_ADDR);
    assign wr_tper  = IOBUS_WR && (IOBUS_ADDR == IO_TPER_ADDR);
    assign wr_istat = IOBUS_WR && (IOBUS_ADDR == IO_ISTAT_ADDR);
    assign wr_imask = IOBUS_WR && (IOBUS_ADDR == IO_IMASK_ADDR);

    // A period write restarts the count, so it also suppresses a wrap on that edge.
    assign tmr_run  = tmr_en && (tper != 32'd0) && !wr_tper;
    assign tmr_wrap = tmr_run && (tcnt == tper - 32'd1);

    always_comb begin
        istat_set = '0;
        istat_set[TMR_PEND_BIT] = tmr_wrap;
        istat_set[BTN_PEND_LSB +: BTN_WIDTH] = btn_rise;
        istat_clr = wr_istat ? IOBUS_OUT[IW-1:0] : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_sync_1 <= '0;
            sw_sync_2 <= '0;
            LEDS      <= '0;
            tmr_en    <= 1'b0;
            tper      <= '0;
            tcnt      <= '0;
            istat     <= '0;
            imask     <= '0;
            INTR      <= 1'b0;
        end else begin
            sw_sync_1 <= SWITCHES;
            sw_sync_2 <= sw_sync_1;
            if (wr_led)   LEDS   <= IOBUS_OUT[LED_WIDTH-1:0];
            if (wr_tctl)  tmr_en <= IOBUS_OUT[0];
            if (wr_imask) imask  <= IOBUS_OUT[IW-1:0];
            if (wr_tper) begin
                tper <= IOBUS_OUT;
                tcnt <= '0;
            end else if (tmr_wrap) begin
                tcnt <= '0;
            end else if (tmr_run) begin
                tcnt <= tcnt + 32'd1;
            end
            // Set after clear so an event on the clearing edge is kept.
            istat <= (istat & ~istat_clr) | istat_set;
            INTR  <= |(istat & imask);
        end
    end

    always_comb begin
        IOBUS_IN = 32'd0;
        case (IOBUS_ADDR)
            IO_SW_ADDR:    IOBUS_IN[SW_WIDTH-1:0]  = sw_sync_2;
            IO_BTN_ADDR:   IOBUS_IN[BTN_WIDTH-1:0] = btn_level;
            IO_LED_ADDR:   IOBUS_IN[LED_WIDTH-1:0] = LEDS;
            IO_TCTL_ADDR:  IOBUS_IN[0]             = tmr_en;
            IO_TPER_ADDR:  IOBUS_IN                = tper;
            IO_TCNT_ADDR:  IOBUS_IN                = tcnt;
            IO_ISTAT_ADDR: IOBUS_IN[IW-1:0]        = istat;
            IO_IMASK_ADDR: IOBUS_IN[IW-1:0]        = imask;
            default:       IOBUS_IN                = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_otter_io_intr_ctrl.sv
// tb/tb_otter_io_intr_ctrl.sv - directed table and sequence checks for otter_io_intr_ctrl
`timescale 1ns/100ps
module tb_otter_io_intr_ctrl;

    localparam logic [31:0] A_SW    = 32'h1100_0000;
    localparam logic [31:0] A_BTN   = 32'h1100_0020;
    localparam logic [31:0] A_LED   = 32'h1100_0040;
    localparam logic [31:0] A_TCTL  = 32'h1100_0060;
    localparam logic [31:0] A_TPER  = 32'h1100_0064;
    localparam logic [31:0] A_TCNT  = 32'h1100_0068;
    localparam logic [31:0] A_ISTAT = 32'h1100_006C;
    localparam logic [31:0] A_IMASK = 32'h1100_0070;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] IOBUS_ADDR = 32'd0;
    logic [31:0] IOBUS_OUT = 32'd0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        INTR;
    logic [15:0] SWITCHES = 16'd0;
    logic [3:0]  BUTTONS = 4'd0;
    logic [15:0] LEDS;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        do_wr;
        logic [31:0] exp_rd;
        logic [15:0] exp_leds;
    } vec_t;

    vec_t vecs[12];

    otter_io_intr_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .INTR(INTR), .SWITCHES(SWITCHES),
        .BUTTONS(BUTTONS), .LEDS(LEDS)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_IN;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] regs[8];
        bit          hit;

        regs = '{A_SW, A_BTN, A_LED, A_TCTL, A_TPER, A_TCNT, A_ISTAT, A_IMASK};

        vecs[0]  = '{A_LED,            32'h0000_A5A5, 1'b1, 32'h0000_A5A5, 16'hA5A5};
        vecs[1]  = '{A_SW,             32'h0000_FFFF, 1'b1, 32'h0000_0000, 16'hA5A5};
        vecs[2]  = '{32'h1100_0010,    32'h0,         1'b0, 32'h0000_0000, 16'hA5A5};
        vecs[3]  = '{A_IMASK,          32'hFFFF_FFFF, 1'b1, 32'h0000_001F, 16'hA5A5};
        vecs[4]  = '{A_IMASK,          32'h0,         1'b1, 32'h0000_0000, 16'hA5A5};
        vecs[5]  = '{A_TCTL,           32'hFFFF_FFFE, 1'b1, 32'h0000_0000, 16'hA5A5};
        vecs[6]  = '{A_TPER,           32'h0000_1234, 1'b1, 32'h0000_1234, 16'hA5A5};
        vecs[7]  = '{A_TCNT,           32'h0,         1'b0, 32'h0000_0000, 16'hA5A5};
        vecs[8]  = '{A_LED,            32'h1234_5678, 1'b1, 32'h0000_5678, 16'h5678};
        vecs[9]  = '{A_TPER,           32'h0,         1'b1, 32'h0000_0000, 16'h5678};
        vecs[10] = '{32'h1100_0044,    32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 16'h5678};
        vecs[11] = '{A_ISTAT,          32'h0,         1'b0, 32'h0000_0000, 16'h5678};

        // Reset state
        repeat (3) @(posedge CLK);
        #5 RST_N = 1'b1;
        tick();
        chk("reset_intr", {31'd0, INTR}, 32'd0);
        chk("reset_leds", {16'd0, LEDS}, 32'd0);
        foreach (regs[i]) rd_chk($sformatf("reset_rd_%08h", regs[i]), regs[i], 32'd0);

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), {16'd0, LEDS}, {16'd0, vecs[i].exp_leds});
        end

        // Switch synchroniser latency
        SWITCHES = 16'h1234;
        tick();
        rd_chk("sw_lat1", A_SW, 32'd0);
        tick();
        rd_chk("sw_lat2", A_SW, 32'h0000_1234);

        // Timer period 5: pend exactly 5 cycles after enable
        wr(A_TPER, 32'd5);
        wr(A_IMASK, 32'd1);
        wr(A_TCTL, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            rd_chk($sformatf("tmr_cnt%0d", k), A_TCNT, k);
            rd_chk($sformatf("tmr_nopend%0d", k), A_ISTAT, 32'd0);
        end
        tick();
        rd_chk("tmr_pend", A_ISTAT, 32'd1);
        rd_chk("tmr_wrap_cnt", A_TCNT, 32'd0);
        chk("tmr_intr_lag", {31'd0, INTR}, 32'd0);
        tick();
        chk("tmr_intr", {31'd0, INTR}, 32'd1);
        wr(A_ISTAT, 32'd1);
        rd_chk("tmr_w1c", A_ISTAT, 32'd0);
        chk("tmr_intr_hold", {31'd0, INTR}, 32'd1);
        tick();
        chk("tmr_intr_drop", {31'd0, INTR}, 32'd0);

        // W1C on the same edge as a wrap: set wins
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            rd(A_TCNT, d);
            if (d == 32'd4) hit = 1;
            else tick();
        end
        chk("w1c_wait_timeout", {31'd0, hit}, 32'd1);
        wr(A_ISTAT, 32'd1);
        rd_chk("w1c_set_wins", A_ISTAT, 32'd1);
        rd_chk("w1c_wrap_cnt", A_TCNT, 32'd0);

        // Masking drops INTR one cycle later, pend retained
        tick();
        chk("mask_intr_hi", {31'd0, INTR}, 32'd1);
        wr(A_TCTL, 32'd0);
        wr(A_IMASK, 32'd0);
        chk("mask_intr_lag", {31'd0, INTR}, 32'd1);
        tick();
        chk("mask_intr_lo", {31'd0, INTR}, 32'd0);
        rd_chk("mask_pend_kept", A_ISTAT, 32'd1);
        wr(A_ISTAT, 32'h1F);

        // Zero period with enable: count holds 0, no pend
        wr(A_TPER, 32'd0);
        wr(A_TCTL, 32'd1);
        repeat (10) tick();
        rd_chk("tper0_cnt", A_TCNT, 32'd0);
        rd_chk("tper0_nopend", A_ISTAT, 32'd0);

        // Reset mid-count with a pending timer interrupt
        wr(A_LED, 32'h0000_00FF);
        wr(A_TPER, 32'd3);
        wr(A_IMASK, 32'd1);
        repeat (5) tick();
        rd_chk("pre_rst_pend", A_ISTAT, 32'd1);
        chk("pre_rst_intr", {31'd0, INTR}, 32'd1);
        #3 RST_N = 1'b0;
        SWITCHES = 16'd0;
        #1;
        chk("rst_intr", {31'd0, INTR}, 32'd0);
        chk("rst_leds", {16'd0, LEDS}, 32'd0);
        rd_chk("rst_tcnt", A_TCNT, 32'd0);
        tick();
        #3 RST_N = 1'b1;
        repeat (2) tick();
        foreach (regs[i]) rd_chk($sformatf("post_rst_rd_%08h", regs[i]), regs[i], 32'd0);
        chk("post_rst_intr", {31'd0, INTR}, 32'd0);

        // Button glitch shorter than the debounce window
        wr(A_IMASK, 32'h8);
        BUTTONS = 4'h4;
        repeat (5) tick();
        BUTTONS = 4'h0;
        repeat (15) tick();
        rd_chk("glitch_btn", A_BTN, 32'd0);
        rd_chk("glitch_pend", A_ISTAT, 32'd0);
        chk("glitch_intr", {31'd0, INTR}, 32'd0);

        // Stable press
        BUTTONS = 4'h4;
        repeat (12) tick();
        rd_chk("press_btn", A_BTN, 32'h4);
        rd_chk("press_pend", A_ISTAT, 32'h8);
        chk("press_intr", {31'd0, INTR}, 32'd1);

        // Release sets no pend
        wr(A_ISTAT, 32'h8);
        BUTTONS = 4'h0;
        repeat (15) tick();
        rd_chk("release_btn", A_BTN, 32'd0);
        rd_chk("release_pend", A_ISTAT, 32'd0);
        chk("release_intr", {31'd0, INTR}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
